// File: rtl/algo_1r1u_rmw.sv
// 1-read/1-update algorithmic memory front-end with read-modify-write opcodes.
// Zero-fills the t1 SRAM after reset and forwards in-flight updates to returning reads.
module algo_1r1u_rmw #(
    parameter int WIDTH      = 32,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int SRAM_DELAY = 2,
    parameter int SATURATE   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ready,

    input  logic               read,
    input  logic [BITADDR-1:0] rd_adr,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dout,
    output logic               rd_fwrd,

    input  logic               write,
    input  logic [1:0]         upd_op,
    input  logic [WIDTH-1:0]   din,
    output logic               upd_err,

    output logic               t1_readA,
    output logic [BITADDR-1:0] t1_addrA,
    input  logic [WIDTH-1:0]   t1_doutA,
    output logic               t1_writeB,
    output logic [BITADDR-1:0] t1_addrB,
    output logic [WIDTH-1:0]   t1_dinB
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [BITADDR-1:0] LAST_ADR = BITADDR'(NUMADDR - 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_SUB   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    state_t               r_state;
    state_t               w_nstate;
    logic [BITADDR-1:0]   r_cnt;

    logic                 w_run;
    logic                 w_acc;

    logic [SRAM_DELAY-1:0] r_pvld;
    logic [BITADDR-1:0]    r_padr [SRAM_DELAY];
    logic                  w_tvld;
    logic [BITADDR-1:0]    w_tadr;

    logic [SRAM_DELAY-1:0] r_hvld;
    logic [BITADDR-1:0]    r_hadr [SRAM_DELAY];
    logic [WIDTH-1:0]      r_hdat [SRAM_DELAY];
    logic                  w_fhit;
    logic [WIDTH-1:0]      w_fdat;

    logic [WIDTH-1:0]      w_old;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_dif;
    logic [WIDTH-1:0]      w_new;
    logic                  w_upd;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + BITADDR'(1);
        end
    end

    // FSM next-state logic: leave INIT after the cycle that clears the last word
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == LAST_ADR) w_nstate = ST_RUN;
            ST_RUN:  w_nstate = ST_RUN;
            default: w_nstate = ST_INIT;
        endcase
    end

    assign w_run = (r_state == ST_RUN);
    assign w_acc = read & w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pvld <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) begin
                r_padr[i] <= '0;
            end
        end else begin
            r_pvld[0] <= w_acc;
            r_padr[0] <= rd_adr;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                r_pvld[i] <= r_pvld[i-1];
                r_padr[i] <= r_padr[i-1];
            end
        end
    end

    assign w_tvld = r_pvld[SRAM_DELAY-1];
    assign w_tadr = r_padr[SRAM_DELAY-1];

    // Entry 0 is the newest update; the window spans exactly the updates t1 cannot see
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hvld <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) begin
                r_hadr[i] <= '0;
                r_hdat[i] <= '0;
            end
        end else begin
            r_hvld[0] <= w_upd;
            r_hadr[0] <= w_tadr;
            r_hdat[0] <= w_new;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                r_hvld[i] <= r_hvld[i-1];
                r_hadr[i] <= r_hadr[i-1];
                r_hdat[i] <= r_hdat[i-1];
            end
        end
    end

    // Scan oldest to newest so the most recent matching update wins
    always_comb begin
        w_fhit = 1'b0;
        w_fdat = '0;
        for (int i = SRAM_DELAY - 1; i >= 0; i--) begin
            if (r_hvld[i] && (r_hadr[i] == w_tadr)) begin
                w_fhit = 1'b1;
                w_fdat = r_hdat[i];
            end
        end
    end

    assign w_old   = w_fhit ? w_fdat : t1_doutA;
    assign rd_vld  = w_tvld;
    assign rd_fwrd = w_tvld & w_fhit;
    assign rd_dout = w_tvld ? w_old : '0;

    assign w_sum = {1'b0, w_old} + {1'b0, din};
    assign w_dif = {1'b0, w_old} - {1'b0, din};

    always_comb begin
        w_new = '0;
        case (upd_op)
            OP_WRITE: w_new = din;
            OP_ADD: begin
                if ((SATURATE != 0) && w_sum[WIDTH]) w_new = '1;
                else                                 w_new = w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                if ((SATURATE != 0) && w_dif[WIDTH]) w_new = '0;
                else                                 w_new = w_dif[WIDTH-1:0];
            end
            OP_CLEAR: w_new = '0;
            default:  w_new = '0;
        endcase
    end

    assign w_upd   = write & w_tvld;
    assign upd_err = write & w_run & ~w_tvld;

    assign t1_readA = w_acc;
    assign t1_addrA = w_acc ? rd_adr : '0;

    // FSM outputs: port B is owned by the sweep in INIT and by updates in RUN
    always_comb begin
        ready     = 1'b0;
        t1_writeB = 1'b0;
        t1_addrB  = '0;
        t1_dinB   = '0;
        case (r_state)
            ST_INIT: begin
                t1_writeB = rst_n;
                t1_addrB  = r_cnt;
            end
            ST_RUN: begin
                ready = 1'b1;
                if (w_upd) begin
                    t1_writeB = 1'b1;
                    t1_addrB  = w_tadr;
                    t1_dinB   = w_new;
                end
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/algo_1r1u_rmw.md
Name: algo_1r1u_rmw

Overview:
- Parametrised successor to the 1-read/1-update algorithmic memory.
- Each read may be followed, exactly SRAM_DELAY cycles later, by an update to the same address.
- The update is now an opcode applied to the returned data: write, add, subtract or clear, with optional saturation.
- Sits between the client pipeline and a single dual-port SRAM macro (t1). It owns power-on zero-initialisation and read-after-update forwarding.

Parameters:
- WIDTH, 32, data width.
- NUMADDR, 8192, number of words.
- BITADDR, 13, address width (>= clog2(NUMADDR)).
- SRAM_DELAY, 2, t1 read latency in cycles (>= 1).
- SATURATE, 1, 1 = add/sub clamp to all-ones/zero; 0 = modulo 2^WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ready  out  1  high once initialisation sweep completes.
- read  in  1  read request.
- rd_adr  in  BITADDR  read address.
- rd_vld  out  1  read data valid, SRAM_DELAY cycles after accepted read.
- rd_dout  out  WIDTH  read data, forwarded if needed.
- rd_fwrd  out  1  rd_dout sourced from in-flight update history, not t1.
- write  in  1  update request; targets address of read returning this cycle.
- upd_op  in  2  0=write din, 1=add din, 2=sub din, 3=clear.
- din  in  WIDTH  update operand.
- upd_err  out  1  pulse: write asserted with no rd_vld this cycle; update dropped.
- t1_readA  out  1  SRAM read enable.
- t1_addrA  out  BITADDR  SRAM read address.
- t1_doutA  in  WIDTH  SRAM read data (valid SRAM_DELAY cycles after t1_readA).
- t1_writeB  out  1  SRAM write enable.
- t1_addrB  out  BITADDR  SRAM write address.
- t1_dinB  out  WIDTH  SRAM write data.

Behaviour:
- **Reset (rst_n low, asynchronous).** Outputs go to: ready=0, rd_vld=0, rd_fwrd=0, upd_err=0, t1_readA=0, t1_writeB=0. All addr/data outputs = 0. Read pipeline and update history are cleared. FSM enters INIT with sweep counter 0.
- **FSM INIT.**
  - Each cycle: t1_writeB=1, t1_addrB=counter, t1_dinB=0, counter++.
  - After the cycle writing NUMADDR-1, go to RUN; ready=1 from the next cycle.
  - INIT lasts exactly NUMADDR cycles after reset release.
  - read/write during INIT are ignored: no rd_vld, no upd_err.
- **Reset mid-operation.** Aborts everything and returns to INIT at counter 0. In-flight reads produce no rd_vld.
- **FSM RUN, read path.**
  - read=1 at cycle T drives t1_readA=1, t1_addrA=rd_adr combinationally.
  - The address enters a SRAM_DELAY-deep valid/address shift pipeline.
  - At T+SRAM_DELAY: rd_vld=1 and rd_dout=t1_doutA, unless forwarded. rd_vld, rd_dout and rd_fwrd are combinational from pipeline tail and history.
  - Back-to-back reads are sustained every cycle.
- **Update path.**
  - Applies when write=1 in a cycle with rd_vld=1; target address = pipeline-tail address; old = rd_dout (post-forwarding).
  - new value by opcode:
    - op0: din.
    - op1: old+din; if SATURATE and carry, all-ones.
    - op2: old-din; if SATURATE and borrow, 0.
    - op3: 0.
  - Same cycle: t1_writeB=1, t1_addrB=tail addr, t1_dinB=new.
  - write=1 with rd_vld=0: upd_err=1 for that cycle, no t1 write.
- **Forwarding.**
  - Keep an update history of the last SRAM_DELAY cycles (valid, addr, data).
  - t1 read returns contents as of issue cycle, so updates in cycles T..T+SRAM_DELAY-1 are invisible to it.
  - At T+SRAM_DELAY, compare the tail address with every valid history entry; newest match wins, rd_fwrd=1.
  - An update issued in the same cycle as the data return is not forwarded to that return; it is the update of that read.
- **Simultaneous read and update** in one cycle is legal: port A reads, port B writes.
- **No other outputs registered.** Latency read→rd_vld is exactly SRAM_DELAY.

Test Plan:
Common configuration: WIDTH=8, NUMADDR=16, SRAM_DELAY=2, SATURATE=1.
- **Reset/init.** Release rst_n. Required: ready=0 for 16 cycles, t1_writeB=1 with addrB 0..15 and dinB=0, ready=1 at cycle 17. read issued at cycle 5 yields no rd_vld.
- **Basic RMW.** Read adr 3 at T; at T+2 write=1, op1, din=5. Required: rd_dout=0, rd_fwrd=0, t1 write addr3 data5. Re-read at T+4 → rd_dout=5, rd_fwrd=0.
- **Back-to-back forwarding.** Reads to adr 7 at T, T+1, T+2, each updated op1 din=1. Required: rd_dout=0,1,2 at T+2..T+4; rd_fwrd=0,1,1; final t1 data 3.
- **Saturation.**
  - write 250 then add 10 → 255 (SATURATE=1).
  - Re-run with SATURATE=0 → 4.
  - Sub 9 from 4 → 0 (SATURATE=1).
- **upd_err.** write=1 with no read two cycles earlier. Required: upd_err=1 for 1 cycle, t1_writeB=0.
- **Mid-run reset.** Assert rst_n low with two reads in flight. Required: rd_vld never asserts for them, ready drops immediately, full 16-cycle INIT repeats.
